// File: rtl/uart_pkg.sv
// Shared UART definitions: frame states, frame geometry and the baud divisor
// calculation used by both the receive and transmit paths.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } uart_state_e;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  localparam int SAMPLE_W   = $clog2(OVERSAMPLE);
  localparam int BIT_W      = $clog2(DATA_BITS);

  // Clocks per sample tick, rounded to nearest.
  function automatic int baud_div(input int clk_freq, input int baud, input int oversample);
    return (clk_freq + (baud * oversample) / 2) / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Sample-tick generator: counts 0..DIV-1 and pulses tick on the last count.
// clear holds the count at zero so the next tick is a full DIV clocks away.
module uart_baud_tick #(
  parameter int DIV = 54
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q;

  assign tick = !clear && (cnt_q == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clear || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver, 8N1 LSB first with 16x oversampling; define UART_RX_PARITY_EN
// for 8E1 frames with a parity_error pulse.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DIV        = baud_div(CLK_FREQ, BAUD, OVERSAMPLE)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        RxD,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        framing_error,
  output logic        overrun,
  output logic        busy,
`ifdef UART_RX_PARITY_EN
  output logic        parity_error,
`endif
  output uart_state_e state_dbg
);

  localparam logic [SAMPLE_W-1:0] MID  = SAMPLE_W'(MID_SAMPLE);
  localparam logic [SAMPLE_W-1:0] LAST = SAMPLE_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]    LAST_BIT = BIT_W'(DATA_BITS - 1);

  uart_state_e             state_q, state_d;
  logic [1:0]              sync_q;
  logic                    rxs;
  logic                    tick;
  logic [SAMPLE_W-1:0]     sample_q, sample_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0]    shift_q, shift_d;
  logic                    byte_done;
  logic                    frame_err;
`ifdef UART_RX_PARITY_EN
  logic                    par_bad_q, par_bad_d;
  logic                    par_err;
`endif

  assign rxs       = sync_q[1];
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear ((state_q == IDLE) || (state_q == WAIT_IDLE)),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q    <= 2'b11;
      state_q   <= IDLE;
      sample_q  <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      sync_q    <= {sync_q[0], RxD};
      state_q   <= state_d;
      sample_q  <= sample_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    sample_d  = sample_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    par_err   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        sample_d = '0;
`ifdef UART_RX_PARITY_EN
        par_bad_d = 1'b0;
`endif
        if (!rxs) state_d = START;
      end
      START: if (tick) begin
        if (sample_q == MID) begin
          sample_d = '0;
          bit_d    = '0;
          state_d  = rxs ? IDLE : DATA;
        end else begin
          sample_d = sample_q + SAMPLE_W'(1);
        end
      end
      DATA: if (tick) begin
        if (sample_q == LAST) begin
          sample_d = '0;
          shift_d  = {rxs, shift_q[DATA_BITS-1:1]};
          bit_d    = bit_q + BIT_W'(1);
`ifdef UART_RX_PARITY_EN
          if (bit_q == LAST_BIT) state_d = PARITY;
`else
          if (bit_q == LAST_BIT) state_d = STOP;
`endif
        end else begin
          sample_d = sample_q + SAMPLE_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) begin
        if (sample_q == LAST) begin
          sample_d  = '0;
          par_bad_d = rxs ^ (^shift_q);
          state_d   = STOP;
        end else begin
          sample_d = sample_q + SAMPLE_W'(1);
        end
      end
`endif
      STOP: if (tick) begin
        if (sample_q == LAST) begin
          sample_d = '0;
`ifdef UART_RX_PARITY_EN
          par_err = par_bad_q;
`endif
          if (rxs) begin
            state_d = IDLE;
`ifdef UART_RX_PARITY_EN
            byte_done = !par_bad_q;
`else
            byte_done = 1'b1;
`endif
          end else begin
            frame_err = 1'b1;
            state_d   = WAIT_IDLE;
          end
        end else begin
          sample_d = sample_q + SAMPLE_W'(1);
        end
      end
      // A held-low line (break) must return high before a new start is armed.
      WAIT_IDLE: if (rxs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake: a byte transfers on any clock where rx_valid && rx_ready; rx_data
  // stays stable while rx_valid is high, and a byte arriving while the previous
  // one is still unaccepted is dropped with an overrun pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_error  <= 1'b0;
`endif
    end else begin
      framing_error <= frame_err;
      overrun       <= byte_done && rx_valid && !rx_ready;
`ifdef UART_RX_PARITY_EN
      parity_error  <= par_err;
`endif
      if (byte_done && (!rx_valid || rx_ready)) begin
        rx_data  <= shift_q;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at 864 clocks per bit; define
// UART_RX_PARITY_EN to run it against the 8E1 build.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int BIT_CLKS = 864;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        RxD;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        framing_error;
  logic        overrun;
  logic        busy;
  uart_state_e state_dbg;
`ifdef UART_RX_PARITY_EN
  logic        parity_error;
`endif

  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int pe_cnt = 0;
  int valid_cycles = 0;
  int got_rd = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  uart_receiver dut (
    .clk           (clk),
    .reset         (reset),
    .RxD           (RxD),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .framing_error (framing_error),
    .overrun       (overrun),
    .busy          (busy),
`ifdef UART_RX_PARITY_EN
    .parity_error  (parity_error),
`endif
    .state_dbg     (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (rx_valid) valid_cycles++;
    if (framing_error) fe_cnt++;
    if (overrun) ov_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_error) pe_cnt++;
`endif
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    RxD = b;
    step(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (PAR) send_bit((^d) ^ par_flip);
    send_bit(stop_b);
  endtask

  // scoreboard
  task automatic sb_check(input string tag);
    check({tag, "_count"}, 32'(got_q.size() - got_rd), 32'(exp_q.size()));
    while (exp_q.size() > 0) begin
      if (got_rd < got_q.size()) begin
        check(tag, 32'(got_q[got_rd]), 32'(exp_q.pop_front()));
        got_rd++;
      end else begin
        void'(exp_q.pop_front());
      end
    end
    got_rd = got_q.size();
  endtask

  initial begin : main
    int fe0, ov0, vc0, pe0;
    reset    = 1'b0;
    RxD      = 1'b1;
    rx_ready = 1'b1;
    step(5);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_data", 32'(rx_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fe", 32'(framing_error), 32'd0);
    check("rst_ov", 32'(overrun), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    reset = 1'b1;
    step(20);

    // single byte, consumer always ready
    vc0 = valid_cycles; fe0 = fe_cnt; ov0 = ov_cnt;
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 1'b0);
    step(20);
    sb_check("b55");
    check("b55_valid_cycles", 32'(valid_cycles - vc0), 32'd1);
    check("b55_fe", 32'(fe_cnt - fe0), 32'd0);
    check("b55_ov", 32'(ov_cnt - ov0), 32'd0);
    check("b55_valid_low", 32'(rx_valid), 32'd0);

    // back-to-back frames with consumer stalled
    rx_ready = 1'b0;
    ov0 = ov_cnt;
    send_frame(8'hA3, 1'b1, 1'b0);
    send_frame(8'h0F, 1'b1, 1'b0);
    step(20);
    check("ovr_pulse", 32'(ov_cnt - ov0), 32'd1);
    check("ovr_valid", 32'(rx_valid), 32'd1);
    check("ovr_data_held", 32'(rx_data), 32'hA3);
    exp_q.push_back(8'hA3);
    rx_ready = 1'b1;
    step(2);
    check("ovr_valid_clr", 32'(rx_valid), 32'd0);
    sb_check("ovr");

    // framing error followed by a 20-bit-time break
    fe0 = fe_cnt; vc0 = valid_cycles;
    send_frame(8'h3C, 1'b0, 1'b0);
    step(19 * BIT_CLKS);
    check("fe_pulse", 32'(fe_cnt - fe0), 32'd1);
    check("fe_no_valid", 32'(valid_cycles - vc0), 32'd0);
    check("fe_busy_break", 32'(busy), 32'd1);
    RxD = 1'b1;
    step(BIT_CLKS);
    check("fe_busy_idle", 32'(busy), 32'd0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, 1'b0);
    step(20);
    sb_check("after_break");
    check("fe_no_extra", 32'(fe_cnt - fe0), 32'd1);

    // 300-clock glitch: start rejected at mid-start, about 435 clocks in
    fe0 = fe_cnt; ov0 = ov_cnt; vc0 = valid_cycles;
    RxD = 1'b0;
    step(300);
    RxD = 1'b1;
    step(120);
    check("glitch_busy_hi", 32'(busy), 32'd1);
    step(30);
    check("glitch_busy_lo", 32'(busy), 32'd0);
    check("glitch_no_evt", 32'((fe_cnt - fe0) + (ov_cnt - ov0) + (valid_cycles - vc0)), 32'd0);
    sb_check("glitch");

    // reset during data bit 4 of 0xFF
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    RxD = 1'b1;
    step(400);
    reset = 1'b0;
    step(3);
    check("mid_rst_valid", 32'(rx_valid), 32'd0);
    check("mid_rst_data", 32'(rx_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_pulses", 32'({framing_error, overrun}), 32'd0);
    reset = 1'b1;
    step(2 * BIT_CLKS);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, 1'b0);
    step(20);
    sb_check("after_rst");

`ifdef UART_RX_PARITY_EN
    pe0 = pe_cnt;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b0);
    step(20);
    sb_check("par_ok");
    check("par_ok_pe", 32'(pe_cnt - pe0), 32'd0);
    vc0 = valid_cycles;
    send_frame(8'h07, 1'b1, 1'b1);
    step(20);
    check("par_bad_pe", 32'(pe_cnt - pe0), 32'd1);
    check("par_bad_no_valid", 32'(valid_cycles - vc0), 32'd0);
    sb_check("par_bad");
`else
    pe0 = pe_cnt;
    check("no_par_pe", 32'(pe_cnt - pe0), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial UART receiver (8N1, LSB first); the counterpart of the board's UART transmit path. Lets the host PC send command bytes (start/stop streaming, axis select) into the accelerometer driver.
- Samples RxD at 16x oversampling and delivers each byte on a valid/ready handshake to the command decoder.
- Flags framing errors and overruns as single-cycle pulses.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits per second.
- OVERSAMPLE, 16, sample ticks per bit; fixed at 16, other values unsupported.
- DIV, CLK_FREQ/(BAUD*OVERSAMPLE) rounded to nearest (54), clocks per sample tick.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- RxD  input  1  asynchronous serial line, idles high.
- rx_data  output  8  received byte; stable while rx_valid=1.
- rx_valid  output  1  byte available; held until accepted.
- rx_ready  input  1  consumer accepts; transfer when rx_valid&&rx_ready.
- framing_error  output  1  one-cycle pulse: stop bit sampled low.
- overrun  output  1  one-cycle pulse: byte completed while previous unaccepted.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset=0, async): state=IDLE; rx_data=0; rx_valid=0; framing_error=0; overrun=0; busy=0; synchronizer flops=1; tick and bit counters=0.
- RxD passes through a 2-flop synchronizer; all decisions use the synchronized value rxs.
- Tick generator: counter 0..DIV-1 emits a tick at DIV-1. Held at 0 in IDLE, so each frame's sampling is phase-aligned to its start-bit detection.
- State machine (advances only on ticks except IDLE):
  - IDLE: rxs==0 → START, sample count=0.
  - START: at sample count 7 (mid-bit), rxs==0 → DATA with bit index 0; rxs==1 → IDLE (glitch rejected, no pulse).
  - DATA: every 16th tick after mid-start, shift rxs into shift register MSB-side (LSB first). After bit index 7 → STOP.
  - STOP: at mid stop bit:
    - rxs==1 → byte complete → IDLE.
    - rxs==0 → framing_error pulse, byte discarded → WAIT_IDLE.
  - WAIT_IDLE: stay until rxs==1, then IDLE. Breaks do not retrigger.
- Delivery: on byte complete, next clk rx_data=shift register and rx_valid=1 (latency one clk after the mid-stop tick).
- Handshake: rx_valid clears the cycle after rx_valid&&rx_ready.
  - Byte completing while rx_valid=1 and rx_ready=0: overrun pulse, new byte dropped, rx_data unchanged.
  - Byte completing in the same cycle as acceptance (rx_valid&&rx_ready): new byte loaded, rx_valid stays 1, no overrun.
- Back-to-back frames: a start bit immediately after the stop sample is detected; no idle gap is required.
- Async reset mid-frame aborts the frame. Reception resumes only at the next falling edge after release.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined: frame is 8E1; an extra PARITY state sits between DATA and STOP and samples the even-parity bit at mid-bit.
  - Mismatch: byte discarded, parity_error output (1 bit, one-cycle pulse) asserted at the stop sample. The frame still completes through STOP/WAIT_IDLE as normal.
- Undefined: 8N1 only; no PARITY state and no parity_error port.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE);
  - DATA_BITS=8, OVERSAMPLE=16, MID_SAMPLE=7;
  - divisor-compute function, shared with the transmit path.
- One sub-module, uart_baud_tick: parameter DIV, input clear, output tick. Reusable by the transmitter.

Test Plan:
- Send 0x55 at 864 clk/bit, rx_ready=1 → rx_valid pulses one cycle with rx_data=0x55; framing_error=0, overrun=0.
- Send 0xA3 then 0x0F back-to-back, rx_ready=0 → rx_data=0xA3 held, overrun pulse at the second stop sample. Then raise rx_ready → rx_data=0xA3 accepted, rx_valid=0.
- Send 0x3C with stop bit forced low → framing_error one-cycle pulse, rx_valid stays 0. Keep RxD low 20 bit times → no further events; release high, send 0x7E → rx_data=0x7E.
- 300-clk low glitch on idle RxD → return to IDLE, no outputs asserted, busy falls after about 440 clks.
- Assert reset at data bit 4 of 0xFF, release, send 0x12 → only 0x12 delivered; all outputs 0 during reset.
- With UART_RX_PARITY_EN: send 0x07 with parity=1 → delivered. Same byte with parity=0 → parity_error pulse, rx_valid stays 0.
